// File: rtl/pipe_stall_ctrl.sv
// Stall/flush controller for the 5-stage RV32I pipeline: owns the IF/ID register,
// steers PC write/select, requests ID/EX bubbles and keeps stall/flush/deadlock telemetry.
module pipe_stall_ctrl #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013,
    parameter int          CNT_W     = 16,
    parameter int          MAX_STALL = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stop,
    input  logic             redirect,
    input  logic [31:0]      redirect_pc,
    input  logic [31:0]      if_pc,
    input  logic [31:0]      if_instr,
    output logic             pc_we,
    output logic             pc_sel,
    output logic [31:0]      pc_target,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_instr,
    output logic             ex_bubble,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             deadlock
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [7:0]       RUN_LIMIT = 8'(MAX_STALL - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic              eff_stall_s;
    logic              pc_we_s;
    logic              pc_sel_s;
    logic [31:0]       pc_target_s;
    logic              ex_bubble_s;
    logic              id_valid_r;
    logic [31:0]       id_pc_r;
    logic [31:0]       id_instr_r;
    logic [CNT_W-1:0]  stall_cnt_r;
    logic [CNT_W-1:0]  flush_cnt_r;
    logic [7:0]        run_cnt_r;
    logic              deadlock_r;

    // A stall request against a bubble is meaningless, and a redirect overrides it.
    assign eff_stall_s = stop & id_valid_r & ~redirect;

    // Next-state selection; redirect wins from every state.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_RUN, ST_STALL, ST_FLUSH: begin
                if (redirect) begin
                    state_nxt_s = ST_FLUSH;
                end else if (eff_stall_s) begin
                    state_nxt_s = ST_STALL;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // Same-cycle PC and bubble controls.
    always_comb begin
        pc_we_s     = 1'b1;
        pc_sel_s    = 1'b0;
        pc_target_s = 32'h0000_0000;
        ex_bubble_s = ~id_valid_r;
        if (redirect) begin
            pc_sel_s    = 1'b1;
            pc_target_s = redirect_pc;
            ex_bubble_s = 1'b1;
        end else if (eff_stall_s) begin
            pc_we_s     = 1'b0;
            ex_bubble_s = 1'b1;
        end else begin
            pc_we_s     = 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // IF/ID pipeline register: squash on redirect, hold on stall, else load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_valid_r <= 1'b0;
            id_pc_r    <= 32'h0000_0000;
            id_instr_r <= NOP_INSTR;
        end else if (redirect) begin
            id_valid_r <= 1'b0;
            id_pc_r    <= 32'h0000_0000;
            id_instr_r <= NOP_INSTR;
        end else if (!eff_stall_s) begin
            id_valid_r <= 1'b1;
            id_pc_r    <= if_pc;
            id_instr_r <= if_instr;
        end else begin
            id_valid_r <= id_valid_r;
            id_pc_r    <= id_pc_r;
            id_instr_r <= id_instr_r;
        end
    end

    // Saturating stall and flush event counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
            flush_cnt_r <= {CNT_W{1'b0}};
        end else begin
            if (eff_stall_s && (stall_cnt_r != CNT_MAX)) begin
                stall_cnt_r <= stall_cnt_r + CNT_ONE;
            end else begin
                stall_cnt_r <= stall_cnt_r;
            end
            if (redirect && (flush_cnt_r != CNT_MAX)) begin
                flush_cnt_r <= flush_cnt_r + CNT_ONE;
            end else begin
                flush_cnt_r <= flush_cnt_r;
            end
        end
    end

    // Consecutive-stall run length and sticky deadlock flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt_r  <= 8'd0;
            deadlock_r <= 1'b0;
        end else if (eff_stall_s) begin
            run_cnt_r  <= (run_cnt_r == 8'hFF) ? run_cnt_r : run_cnt_r + 8'd1;
            deadlock_r <= deadlock_r | (run_cnt_r >= RUN_LIMIT);
        end else begin
            run_cnt_r  <= 8'd0;
            deadlock_r <= deadlock_r;
        end
    end

    assign pc_we     = pc_we_s;
    assign pc_sel    = pc_sel_s;
    assign pc_target = pc_target_s;
    assign ex_bubble = ex_bubble_s;
    assign id_valid  = id_valid_r;
    assign id_pc     = id_pc_r;
    assign id_instr  = id_instr_r;
    assign stall_cnt = stall_cnt_r;
    assign flush_cnt = flush_cnt_r;
    assign deadlock  = deadlock_r;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: a reference model pushes expected IF/ID and
// counter state per cycle, popped after each edge; a narrow-counter copy exercises saturation.
module tb_pipe_stall_ctrl;

    localparam logic [31:0] NOP = 32'h00000013;
    localparam logic [31:0] LW  = 32'h0002a283;
    localparam logic [31:0] ADD = 32'h00628333;
    localparam int          MAX_STALL = 8;

    typedef struct packed {
        logic        id_valid;
        logic [31:0] id_pc;
        logic [31:0] id_instr;
        logic [15:0] stall_cnt;
        logic [15:0] flush_cnt;
        logic        deadlock;
    } obs_t;

    logic clk = 1'b0;
    logic rst, stop, redirect;
    logic [31:0] redirect_pc, if_pc, if_instr;
    logic pc_we, pc_sel, id_valid, ex_bubble, deadlock;
    logic [31:0] pc_target, id_pc, id_instr;
    logic [15:0] stall_cnt, flush_cnt;
    logic s_pc_we, s_pc_sel, s_id_valid, s_ex_bubble, s_deadlock;
    logic [31:0] s_pc_target, s_id_pc, s_id_instr;
    logic [2:0] s_stall_cnt, s_flush_cnt;

    int n_run = 0;
    int n_fail = 0;
    obs_t exp_q[$];
    obs_t m, e, g;
    logic [7:0] m_run;
    logic [34:0] cv, scv, cexp;

    always #5 clk = ~clk;

    pipe_stall_ctrl #(.NOP_INSTR(NOP), .CNT_W(16), .MAX_STALL(MAX_STALL)) dut (
        .clk(clk), .rst(rst), .stop(stop), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_pc(if_pc), .if_instr(if_instr), .pc_we(pc_we), .pc_sel(pc_sel),
        .pc_target(pc_target), .id_valid(id_valid), .id_pc(id_pc), .id_instr(id_instr),
        .ex_bubble(ex_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .deadlock(deadlock)
    );

    pipe_stall_ctrl #(.NOP_INSTR(NOP), .CNT_W(3), .MAX_STALL(MAX_STALL)) dut_s (
        .clk(clk), .rst(rst), .stop(stop), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_pc(if_pc), .if_instr(if_instr), .pc_we(s_pc_we), .pc_sel(s_pc_sel),
        .pc_target(s_pc_target), .id_valid(s_id_valid), .id_pc(s_id_pc), .id_instr(s_id_instr),
        .ex_bubble(s_ex_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt), .deadlock(s_deadlock)
    );

    assign cv  = {pc_we, pc_sel, ex_bubble, pc_target};
    assign scv = {s_pc_we, s_pc_sel, s_ex_bubble, s_pc_target};

    function automatic logic [2:0] sat3(input logic [15:0] v);
        return (v > 16'd7) ? 3'd7 : v[2:0];
    endfunction

    // Reference model of one clock edge; returns the expected post-edge state.
    function automatic obs_t model_step(input logic st, input logic rd,
                                        input logic [31:0] pc, input logic [31:0] ins);
        logic eff;
        eff = st & m.id_valid & ~rd;
        if (eff && m.stall_cnt != 16'hFFFF) m.stall_cnt = m.stall_cnt + 16'd1;
        if (rd && m.flush_cnt != 16'hFFFF) m.flush_cnt = m.flush_cnt + 16'd1;
        if (eff) begin
            if (m_run >= 8'(MAX_STALL - 1)) m.deadlock = 1'b1;
            if (m_run != 8'hFF) m_run = m_run + 8'd1;
        end else begin
            m_run = 8'd0;
        end
        if (rd) begin
            m.id_valid = 1'b0; m.id_pc = 32'd0; m.id_instr = NOP;
        end else if (!eff) begin
            m.id_valid = 1'b1; m.id_pc = pc; m.id_instr = ins;
        end
        return m;
    endfunction

    task automatic reset_model();
        m = '{id_valid: 1'b0, id_pc: 32'd0, id_instr: NOP, stall_cnt: 16'd0, flush_cnt: 16'd0, deadlock: 1'b0};
        m_run = 8'd0;
        exp_q.delete();
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc,
                         input logic [31:0] pc, input logic [31:0] ins);
        stop = st; redirect = rd; redirect_pc = rpc; if_pc = pc; if_instr = ins;
        exp_q.push_back(model_step(st, rd, pc, ins));
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        g = {id_valid, id_pc, id_instr, stall_cnt, flush_cnt, deadlock};
    endtask

    task automatic test_reset();
        rst = 1'b1; stop = 1'b1; redirect = 1'b0; redirect_pc = 32'h44; if_pc = 32'h0; if_instr = ADD;
        reset_model();
        #2;
        g = {id_valid, id_pc, id_instr, stall_cnt, flush_cnt, deadlock};
        n_run++;
        if (g !== m) begin n_fail++; $display("FAIL reset_regs: got %h expected %h", g, m); end
        cexp = {1'b1, 1'b0, 1'b1, 32'h0};
        n_run++;
        if (cv !== cexp || scv !== cexp) begin n_fail++; $display("FAIL reset_comb: got %h/%h expected %h", cv, scv, cexp); end
    endtask

    task automatic test_free_run();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0, 32'(4 * i), ADD + 32'(i));
            cexp = {1'b1, 1'b0, (i == 0), 32'h0};
            n_run++;
            if (cv !== cexp || scv !== cexp) begin n_fail++; $display("FAIL free_run_comb[%0d]: got %h expected %h", i, cv, cexp); end
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (g !== e || id_pc !== 32'(4 * i)) begin n_fail++; $display("FAIL free_run_regs[%0d]: got %h expected %h", i, g, e); end
        end
    endtask

    task automatic test_load_use();
        drive(1'b0, 1'b0, 32'h0, 32'h10, LW);
        tick();
        e = exp_q.pop_front();
        n_run++;
        if (g !== e) begin n_fail++; $display("FAIL load_use_fill: got %h expected %h", g, e); end
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h14, ADD);
            cexp = {1'b0, 1'b0, 1'b1, 32'h0};
            n_run++;
            if (cv !== cexp || scv !== cexp) begin n_fail++; $display("FAIL load_use_comb[%0d]: got %h expected %h", k, cv, cexp); end
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (g !== e || id_instr !== LW || id_pc !== 32'h10) begin n_fail++; $display("FAIL load_use_hold[%0d]: got %h expected %h", k, g, e); end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h14, ADD);
        cexp = {1'b1, 1'b0, 1'b0, 32'h0};
        n_run++;
        if (cv !== cexp) begin n_fail++; $display("FAIL load_use_release_comb: got %h expected %h", cv, cexp); end
        tick();
        e = exp_q.pop_front();
        n_run++;
        if (g !== e || id_instr !== ADD || stall_cnt !== 16'd2) begin n_fail++; $display("FAIL load_use_release: got %h expected %h", g, e); end
    endtask

    task automatic test_redirect_stop();
        drive(1'b1, 1'b1, 32'h00000100, 32'h18, 32'hDEADBEEF);
        cexp = {1'b1, 1'b1, 1'b1, 32'h00000100};
        n_run++;
        if (cv !== cexp || scv !== cexp) begin n_fail++; $display("FAIL redirect_comb: got %h expected %h", cv, cexp); end
        tick();
        e = exp_q.pop_front();
        n_run++;
        if (g !== e || id_valid !== 1'b0 || id_instr !== NOP || flush_cnt !== 16'd1 || stall_cnt !== 16'd2) begin
            n_fail++; $display("FAIL redirect_regs: got %h expected %h", g, e);
        end
    endtask

    task automatic test_stop_bubble();
        drive(1'b1, 1'b0, 32'h0, 32'h100, 32'h00100093);
        cexp = {1'b1, 1'b0, 1'b1, 32'h0};
        n_run++;
        if (cv !== cexp || scv !== cexp) begin n_fail++; $display("FAIL stop_bubble_comb: got %h expected %h", cv, cexp); end
        tick();
        e = exp_q.pop_front();
        n_run++;
        if (g !== e || id_pc !== 32'h100 || stall_cnt !== 16'd2) begin n_fail++; $display("FAIL stop_bubble_regs: got %h expected %h", g, e); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 8; i++) begin
            drive(i[0], 1'b1, 32'h200 + 32'(16 * i), 32'h104, ADD);
            cexp = {1'b1, 1'b1, 1'b1, 32'h200 + 32'(16 * i)};
            n_run++;
            if (cv !== cexp || scv !== cexp) begin n_fail++; $display("FAIL b2b_comb[%0d]: got %h expected %h", i, cv, cexp); end
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (g !== e || s_flush_cnt !== sat3(e.flush_cnt)) begin
                n_fail++; $display("FAIL b2b_regs[%0d]: got %h/%0d expected %h/%0d", i, g, s_flush_cnt, e, sat3(e.flush_cnt));
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h300, LW);
        tick();
        e = exp_q.pop_front();
        n_run++;
        if (g !== e || flush_cnt !== 16'd9 || s_flush_cnt !== 3'd7) begin n_fail++; $display("FAIL b2b_exit: got %h expected %h", g, e); end
    endtask

    task automatic test_deadlock();
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h304, ADD);
            n_run++;
            if (pc_we !== 1'b0 || ex_bubble !== 1'b1) begin n_fail++; $display("FAIL deadlock_comb[%0d]: pc_we %b ex_bubble %b expected 0 1", k, pc_we, ex_bubble); end
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (g !== e || deadlock !== (k >= 7) || s_stall_cnt !== sat3(e.stall_cnt)) begin
                n_fail++; $display("FAIL deadlock_run[%0d]: got %h dl %b expected %h dl %b", k, g, deadlock, e, (k >= 7));
            end
        end
        drive(1'b0, 1'b0, 32'h0, 32'h304, ADD);
        n_run++;
        if (pc_we !== 1'b1) begin n_fail++; $display("FAIL deadlock_release_comb: pc_we %b expected 1", pc_we); end
        tick();
        e = exp_q.pop_front();
        n_run++;
        if (g !== e || deadlock !== 1'b1 || s_deadlock !== 1'b1 || stall_cnt !== 16'd11 || s_stall_cnt !== 3'd7) begin
            n_fail++; $display("FAIL deadlock_sticky: got %h expected %h", g, e);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 2; k++) begin
            drive(1'b1, 1'b0, 32'h0, 32'h308, LW);
            tick();
            e = exp_q.pop_front();
            n_run++;
            if (g !== e) begin n_fail++; $display("FAIL async_pre_stall[%0d]: got %h expected %h", k, g, e); end
        end
        #2 rst = 1'b1;
        #1;
        reset_model();
        g = {id_valid, id_pc, id_instr, stall_cnt, flush_cnt, deadlock};
        cexp = {1'b1, 1'b0, 1'b1, 32'h0};
        n_run++;
        if (g !== m || cv !== cexp || s_stall_cnt !== 3'd0 || s_deadlock !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: got %h comb %h expected %h comb %h", g, cv, m, cexp);
        end
        #1 rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0, 32'h400, ADD);
        tick();
        e = exp_q.pop_front();
        n_run++;
        if (g !== e || id_valid !== 1'b1 || id_pc !== 32'h400) begin n_fail++; $display("FAIL async_first_load: got %h expected %h", g, e); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_load_use();
        test_redirect_stop();
        test_stop_bubble();
        test_back_to_back();
        test_deadlock();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
